fetch_stage: RTL and testbench

- Instruction-fetch stage of the multi-cycle cpu; sits directly upstream of decode and the RegisterFile read ports.
- Owns the PC and issues word requests to instruction memory over a req/gnt + rvalid protocol.
- Presents {instr, pc, pc+4} to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute and discards any in-flight fetch.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and defaults for the multi-cycle cpu.
package cpu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, fetches words over req/gnt/rvalid and hands
// {instr, pc, pc+4} to decode; redirects discard any in-flight fetch.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int             XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  fetch_state_t    state, nextState;
  logic [XLEN-1:0] pc, pcNext;
  logic [XLEN-1:0] pcPlus4;
  logic [XLEN-1:0] redirectAligned;
  logic            loadId;
  logic            clearValid;

  assign pcPlus4         = pc + XLEN'(INSTR_BYTES);
  assign redirectAligned = redirect_pc & ~XLEN'(3);

  assign imem_req  = (state == REQ) && !rst;
  assign imem_addr = pc;

  always_comb begin
    nextState  = state;
    pcNext     = pc;
    loadId     = 1'b0;
    clearValid = 1'b0;
    unique case (state)
      REQ: begin
        if (redirect) begin
          pcNext    = redirectAligned;
          nextState = imem_gnt ? DROP : REQ;
        end else if (imem_gnt) begin
          nextState = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pcNext    = redirectAligned;
          nextState = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid) begin
          loadId    = 1'b1;
          pcNext    = pcPlus4;
          nextState = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          clearValid = 1'b1;
          pcNext     = redirectAligned;
          nextState  = REQ;
        end else if (id_ready) begin
          clearValid = 1'b1;
          nextState  = REQ;
        end
      end
      DROP: begin
        // Stale response is swallowed; only its arrival matters.
        if (redirect) pcNext = redirectAligned;
        if (imem_rvalid) nextState = REQ;
      end
      default: nextState = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
    end else begin
      state <= nextState;
      pc    <= pcNext;
      if (loadId) begin
        id_valid    <= 1'b1;
        id_instr    <= imem_rdata;
        id_pc       <= pc;
        id_pc_plus4 <= pcPlus4;
      end else if (clearValid) begin
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected decode handoffs.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  int errors = 0;
  int checks = 0;
  logic [95:0] sb[$];

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every accepted handoff must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && id_valid && id_ready && !redirect) begin
      logic [95:0] e;
      check("handoff_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_instr", id_instr, e[95:64]);
        check("sb_pc", id_pc, e[63:32]);
        check("sb_pc_plus4", id_pc_plus4, e[31:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    redirect = 0; redirect_pc = '0; id_ready = 0;
    step(); step();
    check("rst_req", 32'(imem_req), 0);
    check("rst_valid", 32'(id_valid), 0);
    check("rst_instr", id_instr, 0);
    check("rst_pc", id_pc, 0);

    rst = 0;
    step();
    check("post_rst_req", 32'(imem_req), 1);
    check("post_rst_addr", imem_addr, 32'h0);
    check("post_rst_valid", 32'(id_valid), 0);

    // basic fetch
    id_ready = 1; imem_gnt = 1;
    step();
    check("wait_req", 32'(imem_req), 0);
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h2002000C;
    sb.push_back({32'h2002000C, 32'h0, 32'h4});
    step();
    check("basic_valid", 32'(id_valid), 1);
    check("basic_instr", id_instr, 32'h2002000C);
    check("basic_pc_plus4", id_pc_plus4, 32'h4);
    imem_rvalid = 0;
    step();
    check("basic_next_valid", 32'(id_valid), 0);
    check("basic_next_addr", imem_addr, 32'h4);
    check("basic_next_req", 32'(imem_req), 1);

    // backpressure
    id_ready = 0; imem_gnt = 1;
    step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h1111_1111;
    sb.push_back({32'h1111_1111, 32'h4, 32'h8});
    step();
    imem_rvalid = 0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(id_valid), 1);
      check("bp_instr", id_instr, 32'h1111_1111);
      check("bp_req", 32'(imem_req), 0);
      step();
    end
    id_ready = 1;
    step();
    check("bp_release_valid", 32'(id_valid), 0);
    check("bp_release_addr", imem_addr, 32'h8);

    // redirect in WAIT, stale data dropped
    imem_gnt = 1;
    step();
    imem_gnt = 0; redirect = 1; redirect_pc = 32'h40;
    step();
    check("drop_req", 32'(imem_req), 0);
    redirect = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 0;
    check("rw_valid", 32'(id_valid), 0);
    check("rw_addr", imem_addr, 32'h40);
    step();
    check("rw_still_invalid", 32'(id_valid), 0);
    imem_gnt = 1;
    step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hAAAA_0001;
    sb.push_back({32'hAAAA_0001, 32'h40, 32'h44});
    step();
    imem_rvalid = 0;
    check("rw_fetch_pc", id_pc, 32'h40);
    step();
    check("rw_next_addr", imem_addr, 32'h44);

    // gnt + redirect in REQ with misaligned target
    imem_gnt = 1; redirect = 1; redirect_pc = 32'h103;
    step();
    imem_gnt = 0; redirect = 0;
    check("gr_req", 32'(imem_req), 0);
    step();
    check("gr_drop_hold", 32'(imem_req), 0);
    imem_rvalid = 1; imem_rdata = 32'hBADB_AD00;
    step();
    imem_rvalid = 0;
    check("gr_addr", imem_addr, 32'h100);
    check("gr_valid", 32'(id_valid), 0);

    // redirect in REQ without gnt
    redirect = 1; redirect_pc = 32'h200;
    step();
    redirect = 0;
    check("rq_addr", imem_addr, 32'h200);
    check("rq_req", 32'(imem_req), 1);

    // redirect in HOLD drops the presented instruction
    id_ready = 0; imem_gnt = 1;
    step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0005;
    step();
    imem_rvalid = 0;
    check("rh_valid", 32'(id_valid), 1);
    check("rh_pc", id_pc, 32'h200);
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 0;
    check("rh_cleared", 32'(id_valid), 0);
    check("rh_addr", imem_addr, 32'hFFFF_FFFC);

    // wrap
    id_ready = 1; imem_gnt = 1;
    step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0077;
    sb.push_back({32'h0000_0077, 32'hFFFF_FFFC, 32'h0});
    step();
    imem_rvalid = 0;
    check("wrap_plus4", id_pc_plus4, 32'h0);
    step();
    check("wrap_addr", imem_addr, 32'h0);

    // reset mid-fetch, late rvalid ignored
    imem_gnt = 1;
    step();
    imem_gnt = 0; rst = 1;
    step();
    check("mid_rst_req", 32'(imem_req), 0);
    check("mid_rst_valid", 32'(id_valid), 0);
    rst = 0; imem_rvalid = 1; imem_rdata = 32'h1234_5678;
    step();
    imem_rvalid = 0;
    check("late_valid", 32'(id_valid), 0);
    check("late_req", 32'(imem_req), 1);
    check("late_addr", imem_addr, 32'h0);
    step();
    check("late_valid2", 32'(id_valid), 0);

    check("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
